// File: rtl/risc_pkg.sv
// Shared core-wide constants: datapath width, instruction width/size, reset PC.
package risc_pkg;
   localparam int          XLEN        = 32;
   localparam int          ILEN        = 32;
   localparam int          INSTR_BYTES = 4;
   localparam logic [31:0] RESET_PC    = 32'h0000_0000;
endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {instr, pc} entries; head is read from storage flops.
module fetch_queue #(
   parameter int               WIDTH = 64,
   parameter int               DEPTH = 4,
   parameter logic [WIDTH-1:0] INIT  = '0
) (
   input  logic                     clk,
   input  logic                     areset,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     not_empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;

   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= INIT;
      end else if (flush) begin
         // flush wins over any push/pop presented in the same cycle
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   assign head      = mem[rd_ptr];
   assign not_empty = (count != '0);
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited request issue, in-order response capture into a
// prefetch queue, and redirect handling that drops responses still in flight.
module fetch_unit #(
   parameter int              XLEN     = risc_pkg::XLEN,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(risc_pkg::RESET_PC)
) (
   input  logic                      clk,
   input  logic                      areset,
   input  logic                      load,
   input  logic                      redir_valid,
   input  logic [XLEN-1:0]           redir_pc,
   output logic                      imem_req_valid,
   output logic [XLEN-1:0]           imem_req_addr,
   input  logic                      imem_req_ready,
   input  logic                      imem_rsp_valid,
   input  logic [risc_pkg::ILEN-1:0] imem_rsp_data,
   output logic                      instr_valid,
   input  logic                      instr_ready,
   output logic [risc_pkg::ILEN-1:0] Instr,
   output logic [XLEN-1:0]           PC,
   output logic                      misalign_err
);
   localparam int              CW   = $clog2(DEPTH) + 1;
   localparam int              QW   = risc_pkg::ILEN + XLEN;
   localparam logic [XLEN-1:0] STEP = XLEN'(risc_pkg::INSTR_BYTES);

   logic [XLEN-1:0] fetch_pc, rsp_pc, redir_tgt;
   logic [CW-1:0]   inflight, drop, occupancy;
   logic [CW:0]     credit_used;
   logic            req_fire, rsp_take, push, pop, q_valid;
   logic [QW-1:0]   q_head;

   assign redir_tgt   = {redir_pc[XLEN-1:2], 2'b00};
   assign credit_used = {1'b0, inflight} + {1'b0, occupancy};

   // Every outstanding request owns a queue slot, so the queue can never overflow.
   assign imem_req_valid = areset & load & ~redir_valid & (credit_used < (CW+1)'(DEPTH));
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid & imem_req_ready;
   assign rsp_take       = imem_rsp_valid & (inflight != '0);
   assign push           = rsp_take & (drop == '0) & ~redir_valid;
   assign pop            = q_valid & instr_ready & ~redir_valid;

   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         fetch_pc     <= RESET_PC;
         rsp_pc       <= RESET_PC;
         inflight     <= '0;
         drop         <= '0;
         misalign_err <= 1'b0;
      end else begin
         inflight     <= inflight + CW'(req_fire) - CW'(rsp_take);
         misalign_err <= redir_valid & (redir_pc[1:0] != 2'b00);
         if (redir_valid) begin
            // a response arriving with the redirect is discarded now, the rest later
            fetch_pc <= redir_tgt;
            rsp_pc   <= redir_tgt;
            drop     <= inflight - CW'(rsp_take);
         end else begin
            if (req_fire)               fetch_pc <= fetch_pc + STEP;
            if (push)                   rsp_pc   <= rsp_pc + STEP;
            if (rsp_take && drop != '0) drop     <= drop - CW'(1);
         end
      end
   end

   fetch_queue #(
      .WIDTH (QW),
      .DEPTH (DEPTH),
      .INIT  ({{risc_pkg::ILEN{1'b0}}, RESET_PC})
   ) u_queue (
      .clk       (clk),
      .areset    (areset),
      .flush     (redir_valid),
      .push      (push),
      .push_data ({imem_rsp_data, rsp_pc}),
      .pop       (pop),
      .head      (q_head),
      .not_empty (q_valid),
      .count     (occupancy)
   );

   assign instr_valid = q_valid;
   assign Instr       = q_head[QW-1:XLEN];
   assign PC          = q_head[XLEN-1:0];
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter XLEN, 32, address/PC width.
REQ-002 SHALL have parameter DEPTH, 4, prefetch queue entries (power of 2, >=2).
REQ-003 SHALL have parameter RESET_PC, 0, PC loaded on reset (word aligned).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port areset  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port load  input  1  fetch enable; 0 blocks new requests only.
REQ-007 SHALL have port redir_valid  input  1  branch/jump redirect strobe.
REQ-008 SHALL have port redir_pc  input  XLEN  redirect target.
REQ-009 SHALL have port imem_req_valid  output  1  instruction-memory request.
REQ-010 SHALL have port imem_req_addr  output  XLEN  request address.
REQ-011 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-012 SHALL have port imem_rsp_valid  input  1  in-order response strobe.
REQ-013 SHALL have port imem_rsp_data  input  32  response instruction word.
REQ-014 SHALL have port instr_valid  output  1  Instr/PC valid to decode.
REQ-015 SHALL have port instr_ready  input  1  decode consumes head.
REQ-016 SHALL have port Instr  output  32  head instruction.
REQ-017 SHALL have port PC  output  XLEN  address of Instr.
REQ-018 SHALL have port misalign_err  output  1  one-cycle pulse: redir_pc[1:0] != 0.

Function
REQ-019 SHALL keep fetch_pc (next request addr), rsp_pc (addr of next kept response), inflight count, drop count, queue occupancy.
REQ-020 SHALL assert imem_req_valid when load=1, redir_valid=0, and inflight + occupancy < DEPTH; imem_req_addr = fetch_pc.
REQ-021 SHALL, on request handshake (valid && ready), increment fetch_pc by 4 (wrap modulo 2^XLEN) and inflight by 1.
REQ-022 SHALL hold imem_req_addr stable while imem_req_valid=1 and ready=0, unless a redirect occurs.
REQ-023 SHALL, on imem_rsp_valid with drop=0, push {imem_rsp_data, rsp_pc} into the queue, rsp_pc += 4, inflight -= 1.
REQ-024 SHALL, on imem_rsp_valid with drop>0, discard the word, drop -= 1, inflight -= 1.
REQ-025 SHALL present the queue head registered: instr_valid = occupancy != 0; pushed word visible one cycle after its response.
REQ-026 SHALL pop head on instr_valid && instr_ready; simultaneous push and pop leaves occupancy unchanged.
REQ-027 SHALL never overflow: credit rule (REQ-020) guarantees a slot for every in-flight response.
REQ-028 SHALL, on redir_valid: flush queue (instr_valid=0 next cycle), fetch_pc and rsp_pc <= {redir_pc[XLEN-1:2],2'b00}, drop <= inflight minus any response in the same cycle.
REQ-029 SHALL suppress any pop in the redirect cycle; instr_ready is ignored then.
REQ-030 SHALL ignore imem_rsp_valid when inflight=0 (protocol violation, no state change).
REQ-031 SHALL pulse misalign_err for exactly the redirect cycle's successor when redir_pc[1:0] != 0.
REQ-032 SHALL allow redirect back-to-back every cycle; drop accumulates correctly.

Reset
REQ-033 SHALL, on areset=0 asynchronously: fetch_pc=rsp_pc=RESET_PC, inflight=drop=occupancy=0, imem_req_valid=0, instr_valid=0, misalign_err=0, Instr=0, PC=RESET_PC.
REQ-034 SHALL, on reset mid-operation, abandon all in-flight requests; memory is reset with the core.
REQ-035 SHALL issue the first request on the first rising edge after areset release with load=1.

Structure
REQ-036 SHALL take XLEN, ILEN=32, INSTR_BYTES=4 and RESET_PC default from shared package risc_pkg.
REQ-037 SHALL implement the queue as sub-module fetch_queue (parametrised width/depth sync FIFO, same clk/areset).

Verification
REQ-038 Reset, load=1, memory ready, 1-cycle latency -> requests 0x0,0x4,0x8,...; Instr/PC pairs match in order, PC=0x0 first.
REQ-039 instr_ready=0 with DEPTH=4 -> exactly 4 requests accepted, then imem_req_valid=0 until a pop.
REQ-040 Redirect to 0x100 with 2 in flight -> next 2 responses dropped; first instr PC=0x100.
REQ-041 Redirect to 0x102 -> misalign_err pulse, fetch resumes at 0x100.
REQ-042 Redirect in the same cycle as a response and a pop -> response dropped, no pop, drop=inflight-1.
REQ-043 fetch_pc at 0xFFFFFFFC -> next request 0x0; areset mid-stream -> all outputs at reset values immediately.
